// File: rtl/reg_word_unloader.sv
// Result-register unloader: captures a W-bit word on load and streams it
// out as W/B beats of B bits over valid/ready. A load that arrives while a
// word is still in flight is discarded and flagged on drop.
module reg_word_unloader #(
    parameter int W         = 32,
    parameter int B         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] D,
    output logic         busy,
    output logic         drop,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [B-1:0] out_data,
    output logic         out_last,
    output logic         done
);
    localparam int N  = W / B;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic          drop_q, drop_d;
    logic [W-1:0]  sr_shifted;

    // Output end of the shift register is the current beat; the shift moves
    // the next beat toward it and zero-fills the far end.
    generate
        if (MSB_FIRST) begin : g_msb
            assign out_data   = sr_q[W-1 -: B];
            assign sr_shifted = sr_q << B;
        end else begin : g_lsb
            assign out_data   = sr_q[B-1:0];
            assign sr_shifted = sr_q >> B;
        end
    endgenerate

    assign busy      = (state_q == SEND);
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign done      = done_q;
    assign drop      = drop_q;

    // Next-state: capture in IDLE, advance one beat per handshake in SEND.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        drop_d  = load && (state_q == SEND);
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SEND;
                    sr_d    = D;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    last_d  = (N == 1);
                end
            end
            SEND: begin
                if (valid_q && out_ready) begin
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = IDLE;
                        sr_d    = '0;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        sr_d   = sr_shifted;
                        cnt_d  = cnt_q + CW'(1);
                        last_d = ((cnt_q + CW'(1)) == CW'(N - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; async reset discards any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end
endmodule

// File: tb/tb_reg_word_unloader.sv
// Directed bench for reg_word_unloader: MSB-first, LSB-first and single-beat
// instances. Inputs change and outputs are sampled on the falling edge.
module tb_reg_word_unloader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // MSB-first 32/8 instance
    logic        load_m = 0, rdy_m = 0;
    logic [31:0] d_m = '0;
    logic        busy_m, drop_m, vld_m, last_m, done_m;
    logic [7:0]  dat_m;
    // LSB-first 32/8 instance
    logic        load_l = 0, rdy_l = 0;
    logic [31:0] d_l = '0;
    logic        busy_l, drop_l, vld_l, last_l, done_l;
    logic [7:0]  dat_l;
    // Single-beat 8/8 instance
    logic        load_o = 0, rdy_o = 0;
    logic [7:0]  d_o = '0;
    logic        busy_o, drop_o, vld_o, last_o, done_o;
    logic [7:0]  dat_o;

    reg_word_unloader #(.W(32), .B(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .load(load_m), .D(d_m), .busy(busy_m), .drop(drop_m),
        .out_valid(vld_m), .out_ready(rdy_m), .out_data(dat_m), .out_last(last_m), .done(done_m));
    reg_word_unloader #(.W(32), .B(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .load(load_l), .D(d_l), .busy(busy_l), .drop(drop_l),
        .out_valid(vld_l), .out_ready(rdy_l), .out_data(dat_l), .out_last(last_l), .done(done_l));
    reg_word_unloader #(.W(8), .B(8), .MSB_FIRST(1'b1)) u_one (
        .clk(clk), .rst(rst), .load(load_o), .D(d_o), .busy(busy_o), .drop(drop_o),
        .out_valid(vld_o), .out_ready(rdy_o), .out_data(dat_o), .out_last(last_o), .done(done_o));

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy_m, drop_m, vld_m, last_m, done_m, dat_m} !== 13'h0) begin
            errors++;
            $display("FAIL reset_msb got %h want 0", {busy_m, drop_m, vld_m, last_m, done_m, dat_m});
        end
        checks++;
        if ({busy_l, drop_l, vld_l, last_l, done_l, dat_l} !== 13'h0) begin
            errors++;
            $display("FAIL reset_lsb got %h want 0", {busy_l, drop_l, vld_l, last_l, done_l, dat_l});
        end
        rst = 1'b0;
        rdy_m = 1'b1;
        // out_ready in IDLE must not produce a beat
        @(negedge clk);
        checks++;
        if (vld_m !== 1'b0 || busy_m !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_beat got vld=%b busy=%b want 0 0", vld_m, busy_m);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        rdy_m = 1'b1; d_m = 32'hA1B2C3D4; load_m = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load_m = 1'b0;
            checks++;
            if ({vld_m, busy_m, dat_m, last_m, done_m} !== {2'b11, exp[i], (i == 3), 1'b0}) begin
                errors++;
                $display("FAIL basic_beat%0d got v=%b b=%b d=%h l=%b dn=%b want d=%h l=%b",
                         i, vld_m, busy_m, dat_m, last_m, done_m, exp[i], (i == 3));
            end
        end
        @(negedge clk);
        checks++;
        if ({done_m, vld_m, busy_m, last_m} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_done got dn=%b v=%b b=%b l=%b want 1 0 0 0", done_m, vld_m, busy_m, last_m);
        end
        @(negedge clk);
        checks++;
        if (done_m !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got %b want 0", done_m);
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        int idx = 0;
        int c = 0;
        d_m = 32'hA1B2C3D4; load_m = 1'b1; rdy_m = 1'b1;
        while (idx < 4 && c < 20) begin
            @(negedge clk);
            load_m = 1'b0;
            c++;
            checks++;
            if (vld_m !== 1'b1 || dat_m !== exp[idx] || last_m !== (idx == 3) || done_m !== 1'b0) begin
                errors++;
                $display("FAIL stall_cyc%0d got v=%b d=%h l=%b dn=%b want d=%h", c, vld_m, dat_m, last_m, done_m, exp[idx]);
            end
            rdy_m = !(c == 2 || c == 3);
            if (rdy_m) idx++;
        end
        @(negedge clk);
        checks++;
        if (done_m !== 1'b1 || vld_m !== 1'b0) begin
            errors++;
            $display("FAIL stall_done got dn=%b v=%b want 1 0 (idx %0d)", done_m, vld_m, idx);
        end
        rdy_m = 1'b1;
    endtask

    task automatic test_drop();
        logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        d_m = 32'h11223344; load_m = 1'b1; rdy_m = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load_m = (i == 1);
            if (i == 1) d_m = 32'h55667788;
            checks++;
            if (dat_m !== exp[i] || vld_m !== 1'b1 || drop_m !== (i == 2)) begin
                errors++;
                $display("FAIL drop_beat%0d got d=%h v=%b drop=%b want d=%h drop=%b", i, dat_m, vld_m, drop_m, exp[i], (i == 2));
            end
        end
        // load during the final-beat handshake is also dropped
        load_m = 1'b1; d_m = 32'h55667788;
        @(negedge clk);
        load_m = 1'b0;
        checks++;
        if (drop_m !== 1'b1 || done_m !== 1'b1 || vld_m !== 1'b0) begin
            errors++;
            $display("FAIL drop_final got drop=%b dn=%b v=%b want 1 1 0", drop_m, done_m, vld_m);
        end
        @(negedge clk);
        checks++;
        if (vld_m !== 1'b0 || busy_m !== 1'b0 || drop_m !== 1'b0) begin
            errors++;
            $display("FAIL drop_nothing_after got v=%b b=%b drop=%b want 0 0 0", vld_m, busy_m, drop_m);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        d_m = 32'hA1B2C3D4; load_m = 1'b1; rdy_m = 1'b1;
        @(negedge clk); load_m = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy_m, drop_m, vld_m, last_m, done_m, dat_m} !== 13'h0) begin
            errors++;
            $display("FAIL reset_mid got %h want 0", {busy_m, drop_m, vld_m, last_m, done_m, dat_m});
        end
        @(negedge clk);
        rst = 1'b0;
        d_m = 32'hDEADBEEF; load_m = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load_m = 1'b0;
            checks++;
            if (dat_m !== exp[i] || vld_m !== 1'b1 || last_m !== (i == 3)) begin
                errors++;
                $display("FAIL reset_reload%0d got d=%h v=%b l=%b want d=%h", i, dat_m, vld_m, last_m, exp[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_lsb_first();
        logic [7:0] exp [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        d_l = 32'hA1B2C3D4; load_l = 1'b1; rdy_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load_l = 1'b0;
            checks++;
            if (dat_l !== exp[i] || vld_l !== 1'b1 || last_l !== (i == 3)) begin
                errors++;
                $display("FAIL lsb_beat%0d got d=%h v=%b l=%b want d=%h l=%b", i, dat_l, vld_l, last_l, exp[i], (i == 3));
            end
        end
        @(negedge clk);
        checks++;
        if (done_l !== 1'b1 || vld_l !== 1'b0) begin
            errors++;
            $display("FAIL lsb_done got dn=%b v=%b want 1 0", done_l, vld_l);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        d_m = 32'h11223344; load_m = 1'b1; rdy_m = 1'b1;
        @(negedge clk); load_m = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        checks++;
        if (done_m !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done got %b want 1", done_m);
        end
        d_m = 32'hCAFEF00D; load_m = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load_m = 1'b0;
            checks++;
            if (dat_m !== exp[i] || vld_m !== 1'b1 || drop_m !== 1'b0 || last_m !== (i == 3)) begin
                errors++;
                $display("FAIL b2b_beat%0d got d=%h v=%b drop=%b l=%b want d=%h", i, dat_m, vld_m, drop_m, last_m, exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (done_m !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done2 got %b want 1", done_m);
        end
    endtask

    task automatic test_single_beat();
        d_o = 8'h5A; load_o = 1'b1; rdy_o = 1'b0;
        @(negedge clk);
        load_o = 1'b0;
        checks++;
        if (dat_o !== 8'h5A || vld_o !== 1'b1 || last_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL one_beat got d=%h v=%b l=%b b=%b want 5a 1 1 1", dat_o, vld_o, last_o, busy_o);
        end
        rdy_o = 1'b1;
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || vld_o !== 1'b0 || last_o !== 1'b0) begin
            errors++;
            $display("FAIL one_done got dn=%b v=%b l=%b want 1 0 0", done_o, vld_o, last_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_drop();
        test_reset_mid();
        test_lsb_first();
        test_back_to_back();
        test_single_beat();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
